// File: rtl/ripple_cap_pkg.sv
// Shared types and default widths for the ripple-counter capture block.
package ripple_cap_pkg;

  parameter int unsigned NDefault    = 4;
  parameter int unsigned AccWDefault = 16;
  parameter int unsigned DwDefault   = 8;

  typedef enum logic {
    INIT,
    TRACK
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus sampled from another clock domain.
module sync_2ff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] s1_q, s2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/ripple_count_capture.sv
// Captures an asynchronous ripple counter, filters ripple transients and reports
// modulo-corrected deltas plus a running total over a valid/ready handshake.
module ripple_count_capture
  import ripple_cap_pkg::*;
#(
  parameter int unsigned N     = NDefault,
  parameter int unsigned ACC_W = AccWDefault,
  parameter int unsigned DW    = DwDefault
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     q_async,
  input  logic             clear,
  input  logic             ready,
  output logic             valid,
  output logic [DW-1:0]    delta_out,
  output logic [ACC_W-1:0] count_out,
  output logic             overflow,
  output logic             lost
);

  logic [N-1:0] s2, s2_d_q;
  logic [1:0]   fill_q;

  sync_2ff #(
    .Width(N)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (q_async),
    .q_o  (s2)
  );

  // fill_q counts edges since reset so the zeros left in the chain by reset
  // are never mistaken for a real sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_d_q <= '0;
      fill_q <= '0;
    end else begin
      s2_d_q <= s2;
      if (fill_q != 2'd3) fill_q <= fill_q + 2'd1;
    end
  end

  logic stable;
  assign stable = (fill_q == 2'd3) && (s2 == s2_d_q);

  // FSM: state register / next state / decoded outputs
  state_e state_q, state_d;
  logic [N-1:0] last_q, last_d;
  logic load_base, accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = INIT;
    end else begin
      unique case (state_q)
        INIT:    if (stable) state_d = TRACK;
        TRACK:   state_d = TRACK;
        default: state_d = INIT;
      endcase
    end
  end

  always_comb begin
    load_base = 1'b0;
    accept    = 1'b0;
    if (!clear) begin
      load_base = (state_q == INIT) && stable;
      accept    = (state_q == TRACK) && stable && (s2 != last_q);
    end
  end

  // Datapath
  logic [ACC_W-1:0] total_q, total_d, count_q, count_d;
  logic [DW-1:0]    pending_q, pending_d, delta_q, delta_d, pend_sat;
  logic             valid_q, valid_d, ovf_q, ovf_d, lost_q, lost_d, slot_free;
  logic [N-1:0]     d_raw;
  logic [ACC_W:0]   total_sum;
  logic [DW:0]      pend_sum;

  // Unsigned N-bit subtraction gives the modulo-2^N delta directly.
  assign d_raw     = s2 - last_q;
  assign total_sum = {1'b0, total_q} + (ACC_W + 1)'(d_raw);
  assign pend_sum  = {1'b0, pending_q} + (DW + 1)'(d_raw);
  assign pend_sat  = pend_sum[DW] ? '1 : pend_sum[DW-1:0];
  assign slot_free = !valid_q || ready;

  always_comb begin
    last_d    = last_q;
    total_d   = total_q;
    pending_d = pending_q;
    valid_d   = valid_q;
    delta_d   = delta_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    lost_d    = lost_q;
    if (clear) begin
      last_d    = '0;
      total_d   = '0;
      pending_d = '0;
      valid_d   = 1'b0;
      ovf_d     = 1'b0;
      lost_d    = 1'b0;
    end else begin
      if (load_base) last_d = s2;
      if (accept) begin
        last_d  = s2;
        total_d = total_sum[ACC_W-1:0];
        if (total_sum[ACC_W]) ovf_d = 1'b1;
        if (pend_sum[DW]) lost_d = 1'b1;
        if (slot_free) begin
          delta_d   = pend_sat;
          count_d   = total_sum[ACC_W-1:0];
          valid_d   = 1'b1;
          pending_d = '0;
        end else begin
          pending_d = pend_sat;
        end
      end else if (slot_free) begin
        if (pending_q != '0) begin
          delta_d   = pending_q;
          count_d   = total_q;
          valid_d   = 1'b1;
          pending_d = '0;
        end else begin
          valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q    <= '0;
      total_q   <= '0;
      pending_q <= '0;
      valid_q   <= 1'b0;
      delta_q   <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      last_q    <= last_d;
      total_q   <= total_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      delta_q   <= delta_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      lost_q    <= lost_d;
    end
  end

  assign valid     = valid_q;
  assign delta_out = delta_q;
  assign count_out = count_q;
  assign overflow  = ovf_q;
  assign lost      = lost_q;

endmodule

// File: doc/ripple_count_capture.md
RIPPLE_COUNT_CAPTURE -- requirements
Module: ripple_count_capture

Interface
REQ-001 Parameter N, default 4: width of the asynchronous ripple-counter value being captured.
REQ-002 Parameter ACC_W, default 16: width of the running total.
REQ-003 Parameter DW, default 8: width of the reported delta and the internal pending register.
REQ-004 clk  input  1  sole clock; all state is on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 q_async  input  N  ripple-counter output, asynchronous to clk, may glitch during ripple.
REQ-007 clear  input  1  synchronous clear of total, pending, flags and baseline.
REQ-008 ready  input  1  consumer accepts delta_out/count_out when ready && valid.
REQ-009 valid  output  1  delta_out/count_out hold a new report.
REQ-010 delta_out  output  DW  counts since previous report, modulo-2^N corrected.
REQ-011 count_out  output  ACC_W  running total of all accepted counts.
REQ-012 overflow  output  1  sticky; total wrapped past 2^ACC_W-1.
REQ-013 lost  output  1  sticky; pending saturated and counts were dropped.

Function
REQ-014 q_async SHALL pass through a two-flop synchronizer (s1, s2), then one further register s2_d.
REQ-015 A sample SHALL be stable when s2 == s2_d; unstable samples are ignored, filtering single-cycle ripple transients.
REQ-016 FSM states: INIT, TRACK. INIT on first stable sample: load baseline last = s2, go to TRACK, no report.
REQ-017 In TRACK, a stable sample with s2 != last is an accept: d = (s2 - last) mod 2^N, zero-extended to DW; last = s2.
REQ-018 On accept, total SHALL add d modulo 2^ACC_W; a carry out SHALL set overflow.
REQ-019 Output slot is free when !valid || ready. On accept with slot free: delta_out = d + pending, count_out = updated total, valid = 1, pending = 0.
REQ-020 On accept with slot busy (valid && !ready): outputs SHALL hold, and pending += d, saturating at 2^DW-1; saturation sets lost.
REQ-021 Slot free, no accept, pending != 0: report pending with the current total, and clear pending.
REQ-022 Slot free, no accept, pending == 0: valid deasserts if ready was high.
REQ-023 Latency: q_async change (meeting setup) to valid high = 4 rising edges.
REQ-024 clear has priority over any same-cycle accept. It sets total = 0, pending = 0, overflow = 0, lost = 0, valid = 0, and state = INIT.
REQ-025 A transfer (valid && ready) in the clear cycle SHALL be considered completed.
REQ-026 delta_out SHALL never be 0 while valid = 1.

Reset
REQ-027 Asynchronous assertion of reset (low) SHALL force state INIT and set all synchronizer, baseline, total and pending registers to 0.
REQ-028 While reset is asserted, valid = 0, delta_out = 0, count_out = 0, overflow = 0 and lost = 0.
REQ-029 Reset mid-operation SHALL discard pending counts. After release, the block re-baselines from the first stable sample.

Structure
REQ-030 Shared package ripple_cap_pkg SHALL hold the state enum (INIT, TRACK) and the default values of N, ACC_W and DW.
REQ-031 The synchronizer SHALL be a sub-module sync_2ff, parameterized by width, with ports clk, reset and an async reset to 0.
REQ-032 All other logic SHALL be in ripple_count_capture; there are no additional clocks or latches.

Verification
REQ-033 Scenario 1: q_async = 4'h5 through reset release, held -> no valid; count_out = 0; baseline 5.
REQ-034 Scenario 2: baseline 5, then q_async = 6 -> valid on 4th edge; delta_out = 1, count_out = 1.
REQ-035 Scenario 3: baseline 4'hE, then q_async = 4'h1 -> delta_out = 3 (wrap-around correct).
REQ-036 Scenario 4: ready = 0 with reported delta 1, then q_async steps +1 twice (each stable) -> outputs held. ready = 1 -> next report delta_out = 2.
REQ-037 Scenario 5: q_async 7 -> 4 for one clk -> 8 -> single report delta_out = 1; the transient 4 is never accepted.
REQ-038 Scenario 6: total at 16'hFFFF, accept d = 2 -> count_out = 16'h0001, overflow = 1. Then clear -> all zero, state INIT.
